// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-library BIST controller and its MISR.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam int          IN_W_DEF   = 16;
    localparam int          OUT_W_DEF  = 10;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [9:0]  MISR_POLY  = 10'h009;

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Pattern/response and status bundle between the BIST controller (master) and its user (slave).
interface gate_bist_ctrl_if
    import gate_bist_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) ();

    logic             start;
    logic [IN_W-1:0]  pattern;
    logic [OUT_W-1:0] response;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] signature;
    logic             pass;

    modport master (
        input  start, response,
        output pattern, busy, done, signature, pass
    );

    modport slave (
        output start, response,
        input  pattern, busy, done, signature, pass
    );

endinterface

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register with synchronous clear and absorb enable.
module gate_bist_misr
    import gate_bist_pkg::*;
#(
    parameter int           W    = OUT_W_DEF,
    parameter logic [W-1:0] POLY = W'(MISR_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_sig,
    output logic [W-1:0] o_sig_next
);

    logic [W-1:0] r_sig;

    assign o_sig_next = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0) ^ i_din;
    assign o_sig      = r_sig;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= o_sig_next;
        end
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST driver for 16-in/10-out gate models: pattern generator, MISR compaction, golden compare.
// Define GATE_BIST_COUNTER_MODE_EN to replace the LFSR with an exhaustive binary up-counter.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int               IN_W         = IN_W_DEF,
    parameter int               OUT_W        = OUT_W_DEF,
    parameter int               NUM_PATTERNS = 256,
    parameter int               SETTLE       = 2,
    parameter logic [15:0]      LFSR_SEED    = 16'hACE1,
    parameter logic [OUT_W-1:0] EXP_SIG      = '0
) (
    input  logic              clk,
    input  logic              rst,
    gate_bist_ctrl_if.master  bif
);

    localparam logic [15:0] HOLD_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] LAST_CNT  = 16'(NUM_PATTERNS - 1);

    bist_state_t      r_state;
    logic [IN_W-1:0]  r_pattern;
    logic [15:0]      r_pat_cnt;
    logic [15:0]      r_hold;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic [IN_W-1:0]  w_pat_next;
    logic [OUT_W-1:0] w_sig;
    logic [OUT_W-1:0] w_sig_next;
    logic             w_launch;
    logic             w_absorb;

`ifdef GATE_BIST_COUNTER_MODE_EN
    localparam logic [IN_W-1:0] SEED_EFF = '0;
    assign w_pat_next = r_pattern + IN_W'(1);
`else
    // A zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [IN_W-1:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? IN_W'(1) : IN_W'(LFSR_SEED);
    localparam logic [IN_W-1:0] TAPS     = IN_W'(LFSR_TAPS);
    assign w_pat_next = {r_pattern[IN_W-2:0], ^(r_pattern & TAPS)};
`endif

    assign w_launch = (r_state != RUN) && bif.start;
    assign w_absorb = (r_state == RUN) && (r_hold == HOLD_LAST);

    gate_bist_misr #(
        .W    (OUT_W),
        .POLY (OUT_W'(MISR_POLY))
    ) u_misr (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_launch),
        .i_en       (w_absorb),
        .i_din      (bif.response),
        .o_sig      (w_sig),
        .o_sig_next (w_sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_pat_cnt <= '0;
            r_hold    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bif.start) begin
                        r_state   <= RUN;
                        r_pattern <= SEED_EFF;
                        r_pat_cnt <= '0;
                        r_hold    <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                    end
                end
                RUN: begin
                    if (r_hold == HOLD_LAST) begin
                        r_hold    <= '0;
                        r_pattern <= w_pat_next;
                        r_pat_cnt <= r_pat_cnt + 16'd1;
                        // Compare against the value being absorbed now so pass lines up with done.
                        if (r_pat_cnt == LAST_CNT) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_sig_next == EXP_SIG);
                        end
                    end else begin
                        r_hold <= r_hold + 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bif.pattern   = r_pattern;
    assign bif.busy      = r_busy;
    assign bif.done      = r_done;
    assign bif.signature = w_sig;
    assign bif.pass      = r_pass;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomized self-checking bench for gate_bist_ctrl with two parameterisations under one clock.
module tb_gate_bist_ctrl;

    localparam int          A_N    = 256;
    localparam int          A_S    = 2;
    localparam logic [15:0] A_SEED = 16'hACE1;
    localparam logic [9:0]  A_EXP  = 10'h000;
    localparam int          B_N    = 4;
    localparam int          B_S    = 1;
    localparam logic [15:0] B_SEED = 16'h0000;
    localparam logic [9:0]  B_EXP  = 10'h00F;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_start;
    logic [9:0] tb_resp;
    logic       sel;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] resp_log [0:255];

    always #5 clk = ~clk;

    gate_bist_ctrl_if if_a ();
    gate_bist_ctrl_if if_b ();

    assign if_a.start    = tb_start & ~sel;
    assign if_b.start    = tb_start & sel;
    assign if_a.response = tb_resp;
    assign if_b.response = tb_resp;

    gate_bist_ctrl #(
        .NUM_PATTERNS (A_N), .SETTLE (A_S), .LFSR_SEED (A_SEED), .EXP_SIG (A_EXP)
    ) u_dut_a (
        .clk (clk), .rst (rst), .bif (if_a)
    );

    gate_bist_ctrl #(
        .NUM_PATTERNS (B_N), .SETTLE (B_S), .LFSR_SEED (B_SEED), .EXP_SIG (B_EXP)
    ) u_dut_b (
        .clk (clk), .rst (rst), .bif (if_b)
    );

    wire [15:0] o_pat  = sel ? if_b.pattern   : if_a.pattern;
    wire [9:0]  o_sig  = sel ? if_b.signature : if_a.signature;
    wire        o_busy = sel ? if_b.busy      : if_a.busy;
    wire        o_done = sel ? if_b.done      : if_a.done;
    wire        o_pass = sel ? if_b.pass      : if_a.pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] first_pat(input logic [15:0] seed);
`ifdef GATE_BIST_COUNTER_MODE_EN
        return 16'h0000 & seed;
`else
        return (seed == 16'h0000) ? 16'h0001 : seed;
`endif
    endfunction

    function automatic logic [15:0] pat_next(input logic [15:0] p);
`ifdef GATE_BIST_COUNTER_MODE_EN
        return p + 16'd1;
`else
        logic fb;
        fb = p[15] ^ p[13] ^ p[12] ^ p[10];
        return {p[14:0], fb};
`endif
    endfunction

    // Signature polynomial x^10 + x^3 + 1 applied to the shifted-out MSB.
    function automatic logic [9:0] misr_next(input logic [9:0] s, input logic [9:0] r);
        logic [9:0] t;
        t = {s[8:0], 1'b0};
        if (s[9]) t = t ^ 10'h009;
        return t ^ r;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_pat"},  32'(o_pat),  32'h0);
        check({tag, "_sig"},  32'(o_sig),  32'h0);
        check({tag, "_busy"}, 32'(o_busy), 32'h0);
        check({tag, "_done"}, 32'(o_done), 32'h0);
        check({tag, "_pass"}, 32'(o_pass), 32'h0);
    endtask

    // mode: 0 random (logged), 1 replay log, 2 tied 0, 3 tied 1
    task automatic run_bist(input int mode, input bit hold_start);
        int          n;
        int          s;
        logic [9:0]  ex;
        logic [15:0] p;
        logic [9:0]  sig;
        logic [9:0]  r;
        n   = sel ? B_N : A_N;
        s   = sel ? B_S : A_S;
        ex  = sel ? B_EXP : A_EXP;
        p   = first_pat(sel ? B_SEED : A_SEED);
        sig = '0;
        tb_start = 1'b1;
        tick();
        if (!hold_start) tb_start = 1'b0;
        check("launch_sig", 32'(o_sig), 32'h0);
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       begin r = 10'($urandom_range(0, 1023)); resp_log[k] = r; end
                1:       r = resp_log[k];
                2:       r = 10'h000;
                default: r = 10'h001;
            endcase
            tb_resp = r;
            for (int h = 0; h < s; h++) begin
                check("run_busy", 32'(o_busy), 32'h1);
                check("run_done", 32'(o_done), 32'h0);
                check("run_pat",  32'(o_pat),  32'(p));
                tick();
            end
            sig = misr_next(sig, r);
            p   = pat_next(p);
            check("run_sig", 32'(o_sig), 32'(sig));
        end
        tb_start = 1'b0;
        check("end_done", 32'(o_done), 32'h1);
        check("end_busy", 32'(o_busy), 32'h0);
        check("end_pass", 32'(o_pass), 32'(sig == ex));
        tb_resp = 10'($urandom_range(0, 1023));
        repeat (3) tick();
        check("hold_done", 32'(o_done), 32'h1);
        check("hold_sig",  32'(o_sig),  32'(sig));
        check("hold_pass", 32'(o_pass), 32'(sig == ex));
    endtask

    task automatic abort_run(input int k);
        int          s;
        logic [15:0] p;
        s = sel ? B_S : A_S;
        p = first_pat(sel ? B_SEED : A_SEED);
        for (int i = 0; i < k; i++) p = pat_next(p);
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        repeat (k * s) tick();
        check("abort_busy", 32'(o_busy), 32'h1);
        check("abort_pat",  32'(o_pat),  32'(p));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("abort_rst");
    endtask

    initial begin
        rst      = 1'b1;
        tb_start = 1'b0;
        tb_resp  = '0;
        sel      = 1'b0;
        repeat (3) tick();
        check_reset("por_a");
        sel = 1'b1;
        #1;
        check_reset("por_b");
        sel = 1'b0;
        rst = 1'b0;
        tick();

        // Long default configuration
        run_bist(0, 1'b0);
        run_bist(1, 1'b0);
        abort_run(2);
        run_bist(1, 1'b0);
        run_bist(2, 1'b0);
        run_bist(0, 1'b1);

        // Short configuration
        sel = 1'b1;
        tick();
        run_bist(3, 1'b0);
        run_bist(2, 1'b0);
        for (int i = 0; i < 4; i++) run_bist(0, (i % 2) == 1);
        abort_run(2);
        run_bist(1, 1'b0);
        run_bist(1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
